// File: rtl/time_keeper.sv
// time_keeper: hours/mins/secs wall clock with user load, edit-mode freeze,
// load accept/reject handshake, minute/day rollover pulses and BCD views.
//
//  state | meaning
//  ------+----------------------------------------------
//  UNSET | no legal time loaded since reset; counting on
//  RUN   | time loaded; counting on
//  HOLD  | user editing (set_mode high); ticks ignored
module time_keeper #(
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       set_mode,
    input  logic       load,
    input  logic [7:0] set_hours,
    input  logic [7:0] set_mins,
    output logic [7:0] hours,
    output logic [7:0] mins,
    output logic [7:0] secs,
    output logic [7:0] hours_bcd,
    output logic [7:0] mins_bcd,
    output logic       time_valid,
    output logic       load_ack,
    output logic       load_err,
    output logic       min_pulse,
    output logic       day_pulse
);

    localparam logic [7:0] HMAX = 8'(HOUR_MAX);

    typedef enum logic [1:0] {UNSET, RUN, HOLD} state_t;

    state_t state;
    state_t state_next;
    logic   load_legal;
    logic   count_en;

    assign load_legal = (set_hours <= HMAX) && (set_mins <= 8'd59);
    assign count_en   = (state != HOLD);

    // Binary (0..99) to two packed BCD digits.
    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 8'd10);
        units = 4'(v % 8'd10);
        return {tens, units};
    endfunction

    // BCD views follow the registers directly, no extra latency.
    always_comb begin
        hours_bcd = to_bcd(hours);
        mins_bcd  = to_bcd(mins);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= UNSET;
        else        state <= state_next;
    end

    // Next-state logic; leaving HOLD also considers a legal load in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            UNSET: begin
                if (set_mode)                 state_next = HOLD;
                else if (load && load_legal)  state_next = RUN;
            end
            RUN: begin
                if (set_mode) state_next = HOLD;
            end
            HOLD: begin
                if (!set_mode)
                    state_next = (time_valid || (load && load_legal)) ? RUN : UNSET;
            end
            default: state_next = UNSET;
        endcase
    end

    // Time registers, load handshake and rollover pulses; load beats tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hours      <= 8'd0;
            mins       <= 8'd0;
            secs       <= 8'd0;
            time_valid <= 1'b0;
            load_ack   <= 1'b0;
            load_err   <= 1'b0;
            min_pulse  <= 1'b0;
            day_pulse  <= 1'b0;
        end else begin
            load_ack  <= 1'b0;
            load_err  <= 1'b0;
            min_pulse <= 1'b0;
            day_pulse <= 1'b0;
            if (load) begin
                if (load_legal) begin
                    hours      <= set_hours;
                    mins       <= set_mins;
                    secs       <= 8'd0;
                    time_valid <= 1'b1;
                    load_ack   <= 1'b1;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick_1hz && count_en) begin
                if (secs == 8'd59) begin
                    secs      <= 8'd0;
                    min_pulse <= 1'b1;
                    if (mins == 8'd59) begin
                        mins <= 8'd0;
                        if (hours == HMAX) begin
                            hours     <= 8'd0;
                            day_pulse <= 1'b1;
                        end else begin
                            hours <= hours + 8'd1;
                        end
                    end else begin
                        mins <= mins + 8'd1;
                    end
                end else begin
                    secs <= secs + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed scenarios followed by random stimulus, all checked
// against a seconds-of-day reference model after every clock edge.
module tb_time_keeper;

    localparam int HMAX = 23;
    localparam int DAY  = (HMAX + 1) * 3600;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic       set_mode;
    logic       load;
    logic [7:0] set_hours;
    logic [7:0] set_mins;
    logic [7:0] hours;
    logic [7:0] mins;
    logic [7:0] secs;
    logic [7:0] hours_bcd;
    logic [7:0] mins_bcd;
    logic       time_valid;
    logic       load_ack;
    logic       load_err;
    logic       min_pulse;
    logic       day_pulse;

    int checks   = 0;
    int failures = 0;

    // Reference model state: time as seconds since midnight.
    int m_t     = 0;
    bit m_valid = 0;
    bit m_hold  = 0;
    bit m_ack   = 0;
    bit m_err   = 0;
    bit m_min   = 0;
    bit m_day   = 0;

    time_keeper #(.HOUR_MAX(HMAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_1hz  (tick_1hz),
        .set_mode  (set_mode),
        .load      (load),
        .set_hours (set_hours),
        .set_mins  (set_mins),
        .hours     (hours),
        .mins      (mins),
        .secs      (secs),
        .hours_bcd (hours_bcd),
        .mins_bcd  (mins_bcd),
        .time_valid(time_valid),
        .load_ack  (load_ack),
        .load_err  (load_err),
        .min_pulse (min_pulse),
        .day_pulse (day_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd_of(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input bit rst_n, input bit ld, input bit tk, input bit sm,
                        input int sh, input int smin);
        int h, m, s;
        reset     = rst_n;
        load      = ld;
        tick_1hz  = tk;
        set_mode  = sm;
        set_hours = 8'(sh);
        set_mins  = 8'(smin);

        if (!rst_n) begin
            m_t = 0; m_valid = 0; m_hold = 0;
            m_ack = 0; m_err = 0; m_min = 0; m_day = 0;
        end else begin
            m_ack = 0; m_err = 0; m_min = 0; m_day = 0;
            if (ld) begin
                if (sh <= HMAX && smin <= 59) begin
                    m_t = sh * 3600 + smin * 60;
                    m_valid = 1;
                    m_ack = 1;
                end else begin
                    m_err = 1;
                end
            end else if (tk && !m_hold) begin
                m_t   = (m_t + 1) % DAY;
                m_min = (m_t % 60) == 0;
                m_day = (m_t == 0);
            end
            m_hold = sm;
        end

        @(posedge clk);
        #1;
        h = m_t / 3600;
        m = (m_t / 60) % 60;
        s = m_t % 60;
        chk("hours",      hours,      8'(h));
        chk("mins",       mins,       8'(m));
        chk("secs",       secs,       8'(s));
        chk("hours_bcd",  hours_bcd,  bcd_of(h));
        chk("mins_bcd",   mins_bcd,   bcd_of(m));
        chk("time_valid", {7'd0, time_valid}, {7'd0, m_valid});
        chk("load_ack",   {7'd0, load_ack},   {7'd0, m_ack});
        chk("load_err",   {7'd0, load_err},   {7'd0, m_err});
        chk("min_pulse",  {7'd0, min_pulse},  {7'd0, m_min});
        chk("day_pulse",  {7'd0, day_pulse},  {7'd0, m_day});
        chk("ack_err_excl", {7'd0, load_ack & load_err}, 8'd0);
    endtask

    initial begin
        int r;
        int sh, smin;
        bit sm_cur;
        int min_count;

        reset = 1'b0; load = 1'b0; tick_1hz = 1'b0; set_mode = 1'b0;
        set_hours = 8'd0; set_mins = 8'd0;

        // Reset, including a load and tick that must be lost.
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 12, 34);
        step(1, 0, 1, 0, 0, 0);

        // Load 12:34 then a full minute of ticks.
        step(1, 1, 0, 0, 12, 34);
        min_count = 0;
        for (int i = 0; i < 60; i++) begin
            step(1, 0, 1, 0, 0, 0);
            if (min_pulse === 1'b1) min_count++;
        end
        chk("min_pulse_count", 8'(min_count), 8'd1);

        // Hold: ticks ignored while editing, then resume.
        step(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);

        // Day wrap from 23:59.
        step(1, 1, 0, 0, 23, 59);
        for (int i = 0; i < 60; i++) step(1, 0, 1, 0, 0, 0);

        // Illegal loads.
        step(1, 1, 0, 0, 24, 0);
        step(1, 1, 0, 0, 10, 60);
        step(1, 0, 0, 0, 0, 0);

        // Load beats a coincident tick.
        step(1, 1, 1, 0, 8, 15);
        step(1, 0, 0, 0, 0, 0);

        // Reset mid-run at 05:06:07.
        step(1, 1, 0, 0, 5, 6);
        for (int i = 0; i < 7; i++) step(1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);

        // Random traffic.
        sm_cur = 0;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            if ($urandom_range(0, 99) < 3) sm_cur = !sm_cur;
            if ($urandom_range(0, 1) == 0) begin
                sh = 23; smin = $urandom_range(58, 61);
            end else begin
                sh = $urandom_range(0, 26); smin = $urandom_range(0, 62);
            end
            step(r >= 2, r >= 2 && r < 17, $urandom_range(0, 9) < 7, sm_cur, sh, smin);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
